// File: rtl/e_pipe_reg_pkg.sv
// Shared Y86-64 encodings and the Decode->Execute field bundle used by the E-stage register.
// Holds the icode, register and status constants plus the bubble value of the E stage.
package e_pipe_reg_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SADR    = 3'd2;
    localparam logic [2:0] SINS    = 3'd3;
    localparam logic [2:0] SHLT    = 3'd4;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } e_fields_t;

    // A bubble is a harmless nop that writes no register and names no source.
    function automatic e_fields_t bubble_fields();
        e_fields_t b;
        b.stat  = SAOK;
        b.icode = INOP;
        b.ifun  = 4'h0;
        b.valC  = 64'h0;
        b.valA  = 64'h0;
        b.valB  = 64'h0;
        b.dstE  = RNONE;
        b.dstM  = RNONE;
        b.srcA  = RNONE;
        b.srcB  = RNONE;
        return b;
    endfunction

endpackage

// File: rtl/e_pipe_reg_hazard.sv
// Combinational E-stage hazard detection: load/use on the instruction in E and jump mispredict.
// Both outputs depend only on the registered E fields and the current decode sources.
module e_hazard_det
    import e_pipe_reg_pkg::*;
(
    input  logic [3:0] e_icode,
    input  logic [3:0] e_dstm,
    input  logic [3:0] d_srca,
    input  logic [3:0] d_srcb,
    input  logic       e_cnd,
    output logic       load_use,
    output logic       mispredict
);

    logic is_load;
    logic src_match;

    // Jumps are predicted taken, so a not-taken jump in E means the fetched path is wrong.
    always_comb begin
        mispredict = (e_icode == IJXX) && !e_cnd;
    end

    always_comb begin
        is_load   = (e_icode == IMRMOVQ) || (e_icode == IPOPQ);
        src_match = (e_dstm == d_srca) || (e_dstm == d_srcb);
        load_use  = is_load && (e_dstm != RNONE) && src_match;
    end

endmodule

// File: rtl/e_pipe_reg.sv
// Decode->Execute pipeline register with hazard-driven bubble insertion and a saturating bubble counter.
// Priority on each edge is external stall, then bubble, then normal load from decode.
module e_pipe_reg
    import e_pipe_reg_pkg::*;
#(
    parameter int BUB_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 stall_i,
    input  logic [2:0]           d_stat_i,
    input  logic [3:0]           d_icode_i,
    input  logic [3:0]           d_ifun_i,
    input  logic [63:0]          d_valC_i,
    input  logic [63:0]          d_valA_i,
    input  logic [63:0]          d_valB_i,
    input  logic [3:0]           d_dstE_i,
    input  logic [3:0]           d_dstM_i,
    input  logic [3:0]           d_srcA_i,
    input  logic [3:0]           d_srcB_i,
    input  logic                 e_Cnd_i,
    output logic [2:0]           E_stat_o,
    output logic [3:0]           E_icode_o,
    output logic [3:0]           E_ifun_o,
    output logic [63:0]          E_valC_o,
    output logic [63:0]          E_valA_o,
    output logic [63:0]          E_valB_o,
    output logic [3:0]           E_dstE_o,
    output logic [3:0]           E_dstM_o,
    output logic [3:0]           E_srcA_o,
    output logic [3:0]           E_srcB_o,
    output logic                 load_use_o,
    output logic                 mispredict_o,
    output logic [BUB_CNT_W-1:0] bubble_cnt_o
);

    e_fields_t           e_q;
    e_fields_t           d_in;
    logic                bubble;
    logic [BUB_CNT_W-1:0] cnt_q;

    always_comb begin
        d_in.stat  = d_stat_i;
        d_in.icode = d_icode_i;
        d_in.ifun  = d_ifun_i;
        d_in.valC  = d_valC_i;
        d_in.valA  = d_valA_i;
        d_in.valB  = d_valB_i;
        d_in.dstE  = d_dstE_i;
        d_in.dstM  = d_dstM_i;
        d_in.srcA  = d_srcA_i;
        d_in.srcB  = d_srcB_i;
    end

    e_hazard_det u_hazard (
        .e_icode    (e_q.icode),
        .e_dstm     (e_q.dstM),
        .d_srca     (d_srcA_i),
        .d_srcb     (d_srcB_i),
        .e_cnd      (e_Cnd_i),
        .load_use   (load_use_o),
        .mispredict (mispredict_o)
    );

    // A simultaneous load/use and mispredict still collapses into one bubble.
    assign bubble = load_use_o || mispredict_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            e_q <= bubble_fields();
        end else if (stall_i) begin
            e_q <= e_q;
        end else if (bubble) begin
            e_q <= bubble_fields();
        end else begin
            e_q <= d_in;
        end
    end

    // Counter only advances on bubbles that actually land, i.e. not while stalled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (!stall_i && bubble && (cnt_q != {BUB_CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + BUB_CNT_W'(1);
        end
    end

    assign E_stat_o     = e_q.stat;
    assign E_icode_o    = e_q.icode;
    assign E_ifun_o     = e_q.ifun;
    assign E_valC_o     = e_q.valC;
    assign E_valA_o     = e_q.valA;
    assign E_valB_o     = e_q.valB;
    assign E_dstE_o     = e_q.dstE;
    assign E_dstM_o     = e_q.dstM;
    assign E_srcA_o     = e_q.srcA;
    assign E_srcB_o     = e_q.srcB;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_e_pipe_reg.sv
// Directed self-checking bench for e_pipe_reg: a 16-bit-counter instance plus a 2-bit one for saturation.
module tb_e_pipe_reg;

    logic        clk_i;
    logic        rst_n_i;
    logic        stall_i;
    logic [2:0]  d_stat_i;
    logic [3:0]  d_icode_i;
    logic [3:0]  d_ifun_i;
    logic [63:0] d_valC_i;
    logic [63:0] d_valA_i;
    logic [63:0] d_valB_i;
    logic [3:0]  d_dstE_i;
    logic [3:0]  d_dstM_i;
    logic [3:0]  d_srcA_i;
    logic [3:0]  d_srcB_i;
    logic        e_Cnd_i;

    logic [2:0]  E_stat_o;
    logic [3:0]  E_icode_o;
    logic [3:0]  E_ifun_o;
    logic [63:0] E_valC_o;
    logic [63:0] E_valA_o;
    logic [63:0] E_valB_o;
    logic [3:0]  E_dstE_o;
    logic [3:0]  E_dstM_o;
    logic [3:0]  E_srcA_o;
    logic [3:0]  E_srcB_o;
    logic        load_use_o;
    logic        mispredict_o;
    logic [15:0] bubble_cnt_o;

    logic [2:0]  s_stat;
    logic [3:0]  s_icode;
    logic [3:0]  s_ifun;
    logic [63:0] s_valC;
    logic [63:0] s_valA;
    logic [63:0] s_valB;
    logic [3:0]  s_dstE;
    logic [3:0]  s_dstM;
    logic [3:0]  s_srcA;
    logic [3:0]  s_srcB;
    logic        s_load_use;
    logic        s_mispredict;
    logic [1:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    e_pipe_reg #(.BUB_CNT_W(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i),
        .d_stat_i(d_stat_i), .d_icode_i(d_icode_i), .d_ifun_i(d_ifun_i),
        .d_valC_i(d_valC_i), .d_valA_i(d_valA_i), .d_valB_i(d_valB_i),
        .d_dstE_i(d_dstE_i), .d_dstM_i(d_dstM_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .e_Cnd_i(e_Cnd_i),
        .E_stat_o(E_stat_o), .E_icode_o(E_icode_o), .E_ifun_o(E_ifun_o),
        .E_valC_o(E_valC_o), .E_valA_o(E_valA_o), .E_valB_o(E_valB_o),
        .E_dstE_o(E_dstE_o), .E_dstM_o(E_dstM_o), .E_srcA_o(E_srcA_o), .E_srcB_o(E_srcB_o),
        .load_use_o(load_use_o), .mispredict_o(mispredict_o), .bubble_cnt_o(bubble_cnt_o)
    );

    e_pipe_reg #(.BUB_CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i),
        .d_stat_i(d_stat_i), .d_icode_i(d_icode_i), .d_ifun_i(d_ifun_i),
        .d_valC_i(d_valC_i), .d_valA_i(d_valA_i), .d_valB_i(d_valB_i),
        .d_dstE_i(d_dstE_i), .d_dstM_i(d_dstM_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .e_Cnd_i(e_Cnd_i),
        .E_stat_o(s_stat), .E_icode_o(s_icode), .E_ifun_o(s_ifun),
        .E_valC_o(s_valC), .E_valA_o(s_valA), .E_valB_o(s_valB),
        .E_dstE_o(s_dstE), .E_dstM_o(s_dstM), .E_srcA_o(s_srcA), .E_srcB_o(s_srcB),
        .load_use_o(s_load_use), .mispredict_o(s_mispredict), .bubble_cnt_o(s_cnt)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_d(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] valA,
                         input logic [3:0] dstE, input logic [3:0] dstM,
                         input logic [3:0] srcA, input logic [3:0] srcB);
        d_stat_i  = 3'd1;
        d_icode_i = icode;
        d_ifun_i  = ifun;
        d_valC_i  = 64'h0;
        d_valA_i  = valA;
        d_valB_i  = 64'h0;
        d_dstE_i  = dstE;
        d_dstM_i  = dstM;
        d_srcA_i  = srcA;
        d_srcB_i  = srcB;
        #1;
    endtask

    task automatic test_reset();
        set_d(4'h6, 4'h0, 64'h1234, 4'h3, 4'hF, 4'h1, 4'h2);
        step();
        checks++;
        if (E_icode_o !== 4'h6) begin
            errors++; $display("[TB] FAIL reset_preload icode got %h want 6", E_icode_o);
        end
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (E_icode_o !== 4'h1) begin
            errors++; $display("[TB] FAIL reset_icode got %h want 1", E_icode_o);
        end
        checks++;
        if (E_dstE_o !== 4'hF || E_srcA_o !== 4'hF || E_dstM_o !== 4'hF || E_srcB_o !== 4'hF) begin
            errors++; $display("[TB] FAIL reset_regs got dstE=%h srcA=%h dstM=%h srcB=%h want F",
                               E_dstE_o, E_srcA_o, E_dstM_o, E_srcB_o);
        end
        checks++;
        if (E_valA_o !== 64'h0 || E_stat_o !== 3'd1) begin
            errors++; $display("[TB] FAIL reset_vals got valA=%h stat=%h want 0/1", E_valA_o, E_stat_o);
        end
        checks++;
        if (bubble_cnt_o !== 16'd0 || s_cnt !== 2'd0) begin
            errors++; $display("[TB] FAIL reset_cnt got %0d/%0d want 0", bubble_cnt_o, s_cnt);
        end
        step();
        rst_n_i = 1'b1;
        #1;
    endtask

    task automatic test_pass_through();
        e_Cnd_i = 1'b1;
        set_d(4'h6, 4'h0, 64'h5, 4'h3, 4'hF, 4'hF, 4'hF);
        step();
        checks++;
        if (E_icode_o !== 4'h6 || E_valA_o !== 64'h5 || E_dstE_o !== 4'h3) begin
            errors++; $display("[TB] FAIL pass_through got icode=%h valA=%h dstE=%h want 6/5/3",
                               E_icode_o, E_valA_o, E_dstE_o);
        end
        checks++;
        if (load_use_o !== 1'b0 || mispredict_o !== 1'b0 || bubble_cnt_o !== 16'd0) begin
            errors++; $display("[TB] FAIL pass_no_hazard got lu=%b mp=%b cnt=%0d want 0/0/0",
                               load_use_o, mispredict_o, bubble_cnt_o);
        end
    endtask

    task automatic test_load_use();
        set_d(4'h5, 4'h0, 64'h0, 4'hF, 4'h2, 4'hF, 4'h4);
        step();
        set_d(4'h6, 4'h0, 64'h77, 4'h6, 4'hF, 4'h2, 4'hF);
        checks++;
        if (load_use_o !== 1'b1) begin
            errors++; $display("[TB] FAIL load_use_detect got %b want 1", load_use_o);
        end
        step();
        checks++;
        if (E_icode_o !== 4'h1 || E_dstE_o !== 4'hF || E_valA_o !== 64'h0 || bubble_cnt_o !== 16'd1) begin
            errors++; $display("[TB] FAIL load_use_bubble got icode=%h dstE=%h valA=%h cnt=%0d want 1/F/0/1",
                               E_icode_o, E_dstE_o, E_valA_o, bubble_cnt_o);
        end
        set_d(4'h5, 4'h0, 64'h0, 4'hF, 4'h2, 4'h4, 4'hF);
        step();
        checks++;
        if (load_use_o !== 1'b0 || E_dstM_o !== 4'h2) begin
            errors++; $display("[TB] FAIL load_use_clear got lu=%b dstM=%h want 0/2", load_use_o, E_dstM_o);
        end
        set_d(4'h6, 4'h0, 64'h9, 4'h7, 4'hF, 4'h3, 4'h2);
        checks++;
        if (load_use_o !== 1'b1) begin
            errors++; $display("[TB] FAIL load_use_srcB got %b want 1", load_use_o);
        end
        step();
        checks++;
        if (bubble_cnt_o !== 16'd2) begin
            errors++; $display("[TB] FAIL load_use_cnt2 got %0d want 2", bubble_cnt_o);
        end
    endtask

    task automatic test_mispredict();
        e_Cnd_i = 1'b0;
        set_d(4'h7, 4'h1, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        step();
        checks++;
        if (mispredict_o !== 1'b1 || E_icode_o !== 4'h7) begin
            errors++; $display("[TB] FAIL mispredict_detect got mp=%b icode=%h want 1/7", mispredict_o, E_icode_o);
        end
        set_d(4'h6, 4'h0, 64'hAA, 4'h5, 4'hF, 4'hF, 4'hF);
        step();
        checks++;
        if (E_icode_o !== 4'h1 || E_dstE_o !== 4'hF || bubble_cnt_o !== 16'd3) begin
            errors++; $display("[TB] FAIL mispredict_bubble got icode=%h dstE=%h cnt=%0d want 1/F/3",
                               E_icode_o, E_dstE_o, bubble_cnt_o);
        end
        e_Cnd_i = 1'b1;
        set_d(4'h7, 4'h1, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        step();
        set_d(4'h6, 4'h0, 64'hAA, 4'h5, 4'hF, 4'hF, 4'hF);
        checks++;
        if (mispredict_o !== 1'b0) begin
            errors++; $display("[TB] FAIL taken_no_mp got %b want 0", mispredict_o);
        end
        step();
        checks++;
        if (E_icode_o !== 4'h6 || E_valA_o !== 64'hAA || E_dstE_o !== 4'h5 || bubble_cnt_o !== 16'd3) begin
            errors++; $display("[TB] FAIL taken_load got icode=%h valA=%h dstE=%h cnt=%0d want 6/AA/5/3",
                               E_icode_o, E_valA_o, E_dstE_o, bubble_cnt_o);
        end
    endtask

    task automatic test_stall_priority();
        set_d(4'hB, 4'h0, 64'h31, 4'h4, 4'h2, 4'h4, 4'h4);
        step();
        set_d(4'h6, 4'h0, 64'h55, 4'h1, 4'hF, 4'h2, 4'hF);
        stall_i = 1'b1;
        step();
        checks++;
        if (E_icode_o !== 4'hB || E_valA_o !== 64'h31 || E_dstM_o !== 4'h2 || bubble_cnt_o !== 16'd3) begin
            errors++; $display("[TB] FAIL stall_hold got icode=%h valA=%h dstM=%h cnt=%0d want B/31/2/3",
                               E_icode_o, E_valA_o, E_dstM_o, bubble_cnt_o);
        end
        checks++;
        if (load_use_o !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_lu_visible got %b want 1", load_use_o);
        end
        stall_i = 1'b0;
        step();
        checks++;
        if (E_icode_o !== 4'h1 || bubble_cnt_o !== 16'd4) begin
            errors++; $display("[TB] FAIL stall_release got icode=%h cnt=%0d want 1/4", E_icode_o, bubble_cnt_o);
        end
    endtask

    task automatic test_saturation();
        rst_n_i = 1'b0;
        #1;
        rst_n_i = 1'b1;
        e_Cnd_i = 1'b0;
        set_d(4'h7, 4'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (s_cnt !== 2'd3 || bubble_cnt_o !== 16'd3) begin
            errors++; $display("[TB] FAIL sat_three got %0d/%0d want 3/3", s_cnt, bubble_cnt_o);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (s_cnt !== 2'd3) begin
            errors++; $display("[TB] FAIL sat_hold got %0d want 3", s_cnt);
        end
        checks++;
        if (bubble_cnt_o !== 16'd5) begin
            errors++; $display("[TB] FAIL sat_wide got %0d want 5", bubble_cnt_o);
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        stall_i = 1'b0;
        e_Cnd_i = 1'b1;
        set_d(4'h1, 4'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        step();
        step();
        rst_n_i = 1'b1;
        #1;
        test_reset();
        test_pass_through();
        test_load_use();
        test_mispredict();
        test_stall_priority();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
